// File: rtl/frame_pkg.sv
// Shared frame-buffer constants and types used by the label writer and the frame reader.
package frame_pkg;

    localparam int HORIZONTAL  = 320;
    localparam int VERTICAL    = 240;
    localparam int PIXEL_BITS  = 3;
    localparam int NUM_CENTERS = 2 ** PIXEL_BITS;
    localparam int ADDR_BITS   = 17;
    localparam int DIST_BITS   = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [PIXEL_BITS-1:0] label_t;
    typedef logic [DIST_BITS-1:0]  dist_t;

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

    // Three 8-bit absolute differences sum to at most 765, so 10 bits never overflow.
    function automatic dist_t l1_distance(rgb_t a, rgb_t b);
        logic [7:0] dr;
        logic [7:0] dg;
        logic [7:0] db;
        dr = (a.r > b.r) ? a.r - b.r : b.r - a.r;
        dg = (a.g > b.g) ? a.g - b.g : b.g - a.g;
        db = (a.b > b.b) ? a.b - b.b : b.b - a.b;
        return dist_t'(dr) + dist_t'(dg) + dist_t'(db);
    endfunction

endpackage

// File: rtl/frame_label_writer_palette_nearest.sv
// Palette registers plus a two-stage nearest-centre search (L1 distances, then argmin).
module palette_nearest #(
    parameter int ADDR_BITS = frame_pkg::ADDR_BITS
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_pal_we,
    input  logic [frame_pkg::PIXEL_BITS-1:0] i_pal_idx,
    input  logic [23:0]                      i_pal_rgb,
    input  logic                             i_valid,
    input  logic [23:0]                      i_rgb,
    input  logic [ADDR_BITS-1:0]             i_addr,
    output logic                             o_valid,
    output logic [ADDR_BITS-1:0]             o_addr,
    output logic [frame_pkg::PIXEL_BITS-1:0] o_label
);
    import frame_pkg::*;

    rgb_t                 palette_q [NUM_CENTERS];
    rgb_t                 palette_d [NUM_CENTERS];
    dist_t                dist_q    [NUM_CENTERS];
    dist_t                dist_d    [NUM_CENTERS];
    logic                 s1_valid_q, s1_valid_d;
    logic [ADDR_BITS-1:0] s1_addr_q,  s1_addr_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [ADDR_BITS-1:0] s2_addr_q,  s2_addr_d;
    label_t               s2_label_q, s2_label_d;
    label_t               best_idx;
    dist_t                best_dist;

    always_comb begin
        palette_d = palette_q;
        if (i_pal_we) begin
            palette_d[i_pal_idx] = rgb_t'(i_pal_rgb);
        end
    end

    always_comb begin
        s1_valid_d = i_valid;
        s1_addr_d  = i_addr;
        for (int k = 0; k < NUM_CENTERS; k++) begin
            dist_d[k] = l1_distance(rgb_t'(i_rgb), palette_q[k]);
        end
    end

    // Strict less-than keeps the earlier centre on equal distances.
    always_comb begin
        best_idx  = '0;
        best_dist = dist_q[0];
        for (int k = 1; k < NUM_CENTERS; k++) begin
            if (dist_q[k] < best_dist) begin
                best_dist = dist_q[k];
                best_idx  = label_t'(k);
            end
        end
        s2_valid_d = s1_valid_q;
        s2_addr_d  = s1_addr_q;
        s2_label_d = best_idx;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_CENTERS; k++) begin
                palette_q[k] <= '0;
                dist_q[k]    <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_label_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CENTERS; k++) begin
                palette_q[k] <= palette_d[k];
                dist_q[k]    <= dist_d[k];
            end
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_label_q <= s2_label_d;
        end
    end

    assign o_valid = s2_valid_q;
    assign o_addr  = s2_addr_q;
    assign o_label = s2_label_q;

endmodule

// File: rtl/frame_label_writer.sv
// Start-frame label writer: 2x2 decimation of a raster RGB stream, palette quantisation,
// and sequential label-memory writes.
module frame_label_writer #(
    parameter int HORIZONTAL = frame_pkg::HORIZONTAL,
    parameter int VERTICAL   = frame_pkg::VERTICAL,
    parameter int ADDR_BITS  = frame_pkg::ADDR_BITS
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [23:0]                      i_rgb,
    input  logic                             i_pal_we,
    input  logic [frame_pkg::PIXEL_BITS-1:0] i_pal_idx,
    input  logic [23:0]                      i_pal_rgb,
    output logic                             o_wr_en,
    output logic [ADDR_BITS-1:0]             o_wr_addr,
    output logic [frame_pkg::PIXEL_BITS-1:0] o_wr_label,
    output logic                             o_busy,
    output logic                             o_done
);
    import frame_pkg::*;

    localparam int X_BITS = $clog2(2 * HORIZONTAL);
    localparam int Y_BITS = $clog2(2 * VERTICAL);
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(2 * HORIZONTAL - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(2 * VERTICAL - 1);

    state_t               state_q, state_d;
    logic [X_BITS-1:0]    x_cnt_q, x_cnt_d;
    logic [Y_BITS-1:0]    y_cnt_q, y_cnt_d;
    logic [ADDR_BITS-1:0] wr_cnt_q, wr_cnt_d;
    logic                 flush_cnt_q, flush_cnt_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 keep;
    logic                 pal_we;

    assign accept = ready_q & i_valid;
    assign keep   = accept & ~x_cnt_q[0] & ~y_cnt_q[0];
    assign pal_we = (state_q == IDLE) & i_pal_we;

    // Raster order means the running count of kept pixels is already y/2*HORIZONTAL + x/2.
    always_comb begin
        state_d     = state_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = CAPTURE;
                    x_cnt_d  = '0;
                    y_cnt_d  = '0;
                    wr_cnt_d = '0;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    if (keep) begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                    if (x_cnt_q == X_LAST) begin
                        x_cnt_d = '0;
                        if (y_cnt_q == Y_LAST) begin
                            y_cnt_d     = '0;
                            state_d     = FLUSH;
                            flush_cnt_d = 1'b0;
                        end else begin
                            y_cnt_d = y_cnt_q + 1'b1;
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = ~flush_cnt_q;
                if (flush_cnt_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == CAPTURE);
        busy_d  = (state_d == CAPTURE) || (state_d == FLUSH);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            wr_cnt_q    <= '0;
            flush_cnt_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    palette_nearest #(
        .ADDR_BITS(ADDR_BITS)
    ) u_nearest (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_pal_we  (pal_we),
        .i_pal_idx (i_pal_idx),
        .i_pal_rgb (i_pal_rgb),
        .i_valid   (keep),
        .i_rgb     (i_rgb),
        .i_addr    (wr_cnt_q),
        .o_valid   (o_wr_en),
        .o_addr    (o_wr_addr),
        .o_label   (o_wr_label)
    );

    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_frame_label_writer.sv
// Self-checking bench for frame_label_writer on a reduced 20x6 stored frame (40x12 input),
// comparing every label write against a behavioural quantiser model and hand-computed tables.
module tb_frame_label_writer;

    localparam int H    = 20;
    localparam int V    = 6;
    localparam int AW   = 17;
    localparam int PB   = 3;
    localparam int IW   = 2 * H;
    localparam int IH   = 2 * V;
    localparam int NPIX = IW * IH;
    localparam int NWR  = H * V;
    localparam int NVEC = 11;

    localparam int M_TABLE = 0;
    localparam int M_CONST = 1;
    localparam int M_GRAD  = 2;
    localparam int M_RAND  = 3;
    localparam int M_TIE   = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic          i_valid;
    logic          o_ready;
    logic [23:0]   i_rgb;
    logic          i_pal_we;
    logic [PB-1:0] i_pal_idx;
    logic [23:0]   i_pal_rgb;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [PB-1:0] o_wr_label;
    logic          o_busy;
    logic          o_done;

    always #5 i_clk = ~i_clk;

    frame_label_writer #(
        .HORIZONTAL(H),
        .VERTICAL  (V),
        .ADDR_BITS (AW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_rgb     (i_rgb),
        .i_pal_we  (i_pal_we),
        .i_pal_idx (i_pal_idx),
        .i_pal_rgb (i_pal_rgb),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_label(o_wr_label),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    typedef struct {
        int addr;
        int label;
        int cyc;
    } exp_t;

    typedef struct {
        logic [23:0] rgb;
        int          exp_label;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        std_vecs[NVEC];
    logic [23:0] ref_pal[8];
    logic [23:0] std_pal[8];

    int checks         = 0;
    int errors         = 0;
    int cyc            = 0;
    int wr_count       = 0;
    int last_acc_cyc   = 0;
    int target_addr    = -1;
    int target_acc_cyc = -1;
    int target_wr_cyc  = -1;
    bit mon_en         = 1'b0;

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Nearest palette centre by L1 distance, lowest index on ties.
    function automatic int ref_label(logic [23:0] px);
        int best;
        int bestd;
        int d;
        int a;
        int b;
        best  = 0;
        bestd = 1 << 30;
        for (int k = 0; k < 8; k++) begin
            d = 0;
            for (int c = 0; c < 3; c++) begin
                a = int'(px[8*c +: 8]);
                b = int'(ref_pal[k][8*c +: 8]);
                d += (a > b) ? a - b : b - a;
            end
            if (d < bestd) begin
                bestd = d;
                best  = k;
            end
        end
        return best;
    endfunction

    function automatic logic [23:0] gen_pixel(int mode, int x, int y);
        logic [23:0] px;
        logic [7:0]  xr;
        px = 24'($urandom);
        xr = 8'(x);
        case (mode)
            M_TABLE: if (x % 2 == 0 && y % 2 == 0) px = std_vecs[((y / 2) * H + x / 2) % NVEC].rgb;
            M_CONST: px = 24'h10F010;
            M_GRAD:  px = {xr, 16'h0000};
            M_TIE:   px = 24'h100010;
            default: px = 24'($urandom);
        endcase
        return px;
    endfunction

    function automatic int expected_label(int mode, int x, int y, logic [23:0] px);
        case (mode)
            M_TABLE: return std_vecs[((y / 2) * H + x / 2) % NVEC].exp_label;
            M_CONST: return 2;
            M_TIE:   return 1;
            default: return ref_label(px);
        endcase
    endfunction

    task automatic load_entry(int idx, logic [23:0] rgb);
        @(negedge i_clk);
        i_pal_we  = 1'b1;
        i_pal_idx = PB'(idx);
        i_pal_rgb = rgb;
        @(negedge i_clk);
        i_pal_we  = 1'b0;
        ref_pal[idx] = rgb;
    endtask

    // Drives one frame (or its first stop_after pixels) and checks the end-of-frame handshake.
    task automatic applyStimulus(int mode, int gap_pct, int stop_after, bit pulse);
        int p;
        int x;
        int y;
        int guard;
        int waited;
        int wr_before;
        logic [23:0] px;
        wr_before = wr_count;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checkOutput("ready_in_capture", {o_ready, o_busy}, 2'b11);
        p     = 0;
        guard = 0;
        while (p < stop_after && guard < 8 * NPIX + 100) begin
            guard++;
            x  = p % IW;
            y  = p / IW;
            px = gen_pixel(mode, x, y);
            i_valid   = ($urandom_range(99) >= gap_pct);
            i_rgb     = px;
            i_start   = pulse && (p == 50);
            i_pal_we  = pulse && (p == 50);
            i_pal_idx = 3'd3;
            i_pal_rgb = 24'h123456;
            if (i_valid && o_ready) begin
                last_acc_cyc = cyc;
                if (x % 2 == 0 && y % 2 == 0)
                    exp_q.push_back('{(y / 2) * H + x / 2, expected_label(mode, x, y, px), cyc});
                if (x == 6 && y == 4) target_acc_cyc = cyc;
                p++;
            end
            @(negedge i_clk);
        end
        i_valid  = 1'b0;
        i_start  = 1'b0;
        i_pal_we = 1'b0;
        if (p != stop_after) checkOutput("accept_timeout", p, stop_after);
        if (stop_after == NPIX) begin
            waited = 0;
            while (o_done !== 1'b1 && waited < 20) begin
                @(negedge i_clk);
                waited++;
            end
            checkOutput("done_seen", o_done, 1'b1);
            checkOutput("done_timing", cyc - last_acc_cyc, 3);
            @(negedge i_clk);
            checkOutput("done_width_busy", {o_done, o_busy, o_ready}, 3'b000);
            checkOutput("write_count", wr_count - wr_before, NWR);
            checkOutput("queue_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (mon_en && o_wr_en === 1'b1) begin
                wr_count++;
                if (int'(o_wr_addr) == target_addr) target_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", o_wr_addr, 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", o_wr_addr, e.addr);
                    checkOutput("wr_label", o_wr_label, e.label);
                    checkOutput("wr_latency", cyc - e.cyc, 2);
                end
            end
        end
    end

    initial begin
        std_vecs[0]  = '{24'h000000, 0};
        std_vecs[1]  = '{24'hFFFFFF, 7};
        std_vecs[2]  = '{24'h10F010, 2};
        std_vecs[3]  = '{24'hF00000, 1};
        std_vecs[4]  = '{24'h1010F0, 3};
        std_vecs[5]  = '{24'hE0E010, 4};
        std_vecs[6]  = '{24'h10E0E0, 5};
        std_vecs[7]  = '{24'hE010E0, 6};
        std_vecs[8]  = '{24'h808080, 7};
        std_vecs[9]  = '{24'h7F7F7F, 0};
        std_vecs[10] = '{24'h800000, 1};
        std_pal = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFFFFFF};
        for (int k = 0; k < 8; k++) ref_pal[k] = 24'h0;

        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_valid   = 1'b0;
        i_rgb     = '0;
        i_pal_we  = 1'b0;
        i_pal_idx = '0;
        i_pal_rgb = '0;
        repeat (3) @(negedge i_clk);
        checkOutput("reset_outputs", {o_ready, o_busy, o_done, o_wr_en, o_wr_addr, o_wr_label}, 0);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;

        for (int k = 0; k < 8; k++) load_entry(k, std_pal[k]);
        $display("[TB] table frame");
        applyStimulus(M_TABLE, 0, NPIX, 1'b0);
        $display("[TB] constant frame");
        applyStimulus(M_CONST, 0, NPIX, 1'b0);

        $display("[TB] gradient frame");
        target_addr = 2 * H + 3;
        applyStimulus(M_GRAD, 0, NPIX, 1'b0);
        checkOutput("pixel_6_4_latency", target_wr_cyc - target_acc_cyc, 2);
        target_addr = -1;

        $display("[TB] random frame with valid gaps");
        applyStimulus(M_RAND, 50, NPIX, 1'b0);

        $display("[TB] tie frame");
        for (int k = 0; k < 8; k++) load_entry(k, 24'hFFFFFF);
        load_entry(1, 24'h200000);
        load_entry(2, 24'h000020);
        applyStimulus(M_TIE, 0, NPIX, 1'b0);

        $display("[TB] start and palette write pulsed during capture");
        for (int k = 0; k < 8; k++) load_entry(k, 24'($urandom));
        applyStimulus(M_RAND, 20, NPIX, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(M_RAND, 0, 83, 1'b0);
        mon_en = 1'b0;
        exp_q.delete();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        checkOutput("reset_drops_inflight", {o_wr_en, o_busy, o_ready, o_done}, 4'b0000);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checkOutput("no_write_after_reset", {o_wr_en, o_busy}, 2'b00);
        for (int k = 0; k < 8; k++) ref_pal[k] = 24'h0;
        mon_en = 1'b1;
        applyStimulus(M_RAND, 10, NPIX, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_label_writer.md
Name: frame_label_writer

Overview:
- Write side of the palette-indexed start-frame buffer: consumes a 640x480 raster RGB pixel stream and decimates it 2x2 to 320x240.
- Quantises each kept pixel to the nearest of 2**PIXEL_BITS palette centres.
- Writes the resulting label into the label memory at the address the frame reader later fetches (y/2*320 + x/2).
- Sits between the camera/pattern source and the label RAM; the palette is loaded by the host before capture.

Parameters:
HORIZONTAL, 320, stored frame width (input width = 2*HORIZONTAL)
VERTICAL, 240, stored frame height (input height = 2*VERTICAL)
PIXEL_BITS, 3, label width; number of centres = 2**PIXEL_BITS
ADDR_BITS, 17, label memory address width (must cover HORIZONTAL*VERTICAL)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  begin capture of one frame (honoured in IDLE only)
i_valid  in  1  input pixel valid
o_ready  out  1  block can accept a pixel; pixel is accepted on i_valid & o_ready
i_rgb  in  24  input pixel {R,G,B}, 8 bits each, raster order
i_pal_we  in  1  palette write strobe (honoured in IDLE only)
i_pal_idx  in  PIXEL_BITS  palette entry index
i_pal_rgb  in  24  palette entry value {R,G,B}
o_wr_en  out  1  label memory write enable
o_wr_addr  out  ADDR_BITS  label memory address
o_wr_label  out  PIXEL_BITS  label to write
o_busy  out  1  high in CAPTURE and FLUSH
o_done  out  1  one-cycle pulse when a frame has fully been written

Behaviour:
- Reset (synchronous, i_rst_n=0 at a clock edge):
  - state=IDLE; all outputs 0.
  - Palette entries = 24'h0; pixel counters, write counter and pipeline valid bits cleared.
  - No write is issued after reset, even if a pixel was in flight.
- FSM:
  - IDLE: o_ready=0. i_pal_we writes palette[i_pal_idx]. i_start -> CAPTURE and clears x_cnt, y_cnt, wr_cnt.
  - CAPTURE: o_ready=1 (no backpressure; memory always accepts). On each accept, x_cnt increments 0..639, wraps to 0 and increments y_cnt 0..479. Accept at x_cnt=639, y_cnt=479 -> FLUSH.
  - FLUSH: o_ready=0; stay until the pipeline is empty (exactly 2 cycles), then -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- i_start and i_pal_we outside IDLE are ignored. Palette is frozen during capture.
- i_valid while o_ready=0 is ignored; the source must hold the pixel.
- Decimation: a pixel is kept iff x_cnt[0]==0 and y_cnt[0]==0. Discarded pixels still advance the counters.
- Address: wr_cnt counts kept pixels and is used directly as o_wr_addr (raster order makes it equal y/2*HORIZONTAL + x/2; no multiplier). Range 0..HORIZONTAL*VERTICAL-1; never wraps within a frame.
- Nearest search, 2-stage pipeline:
  - Stage 1 (register): per centre k, L1 distance d_k = |R-Rk|+|G-Gk|+|B-Bk|. Per-channel differences are unsigned 8-bit absolute values; the sum is 10 bits, max 765, no overflow.
  - Stage 2 (register): argmin over d_k; ties resolve to the lowest index.
  - Output: o_wr_en=1 with o_wr_addr and o_wr_label valid exactly 2 cycles after the accepting edge of a kept pixel. At most one write per cycle.
- Gaps in i_valid create gaps in o_wr_en; there are no bubbles otherwise.
- Exactly HORIZONTAL*VERTICAL writes per frame. The last write has o_wr_addr=76799 and occurs in FLUSH. o_done follows the cycle after the last write.

Decomposition:
- Shared package frame_pkg:
  - HORIZONTAL, VERTICAL, PIXEL_BITS, NUM_CENTERS, ADDR_BITS constants, shared with the frame reader.
  - rgb_t typedef (24-bit packed struct r,g,b).
  - label_t typedef.
  - state_t enum {IDLE, CAPTURE, FLUSH, DONE}.
- Sub-module palette_nearest: holds the palette registers and runs the 2-stage distance/argmin pipeline (in: valid, rgb, addr; out: valid, addr, label).
- The top-level module holds the FSM, counters and decimation.

Test Plan:
- Palette 0..7 = {000000, FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, FFFFFF}; constant frame 10F010 at full rate -> 76800 writes, all label 2, addr 0..76799 consecutive, o_done pulse 1 cycle after the last write, o_busy low afterwards.
- Raster gradient (pixel = x_cnt value in R) -> only even-x/even-y pixels written. Addr for (x=6,y=4) is 2*320+3=643. Write appears 2 cycles after that pixel's accept.
- Tie: palette[1]=200000, palette[2]=000020, input 100010 (d=32 for both) -> label 1.
- Random i_valid gaps (~50%) -> same addr/label sequence as the full-rate run; write count still 76800.
- Reset asserted mid-frame (after 1000 accepts) -> next cycle no o_wr_en, o_busy=0, palette reads back 0. A new i_start restarts at addr 0.
- i_start and i_pal_we pulsed during CAPTURE -> no restart and palette unchanged. Frame labels match the pre-capture palette.
